mseq_load_packer: RTL and testbench

- Sits directly upstream of the matrix shuffle stage.
- Takes read-data beats from the memory bus, one load command at a time, and packs the useful bytes into sequential-buffer lines.
- Each line is NrExits*DLEN/4 nibbles, with a per-nibble enable, delivered over a valid/ready port.
- Strips the start misalignment, handles beats that straddle line boundaries, and emits a short final line carrying only the valid bytes enabled.

---
 rtl/mseq_load_packer.sv | 150 +++++++++++++++
 tb/tb_mseq_load_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mseq_load_packer.sv
// Packs memory read beats into sequential-buffer lines for the shuffle stage.
// Strips start misalignment, splits straddling beats, emits a short tail line.
module mseq_load_packer #(
    parameter int unsigned NrExits   = 4,
    parameter int unsigned DLEN      = 64,
    parameter int unsigned BeatBytes = 16,
    parameter int unsigned LenBits   = 16,
    localparam int unsigned LineBytes = NrExits * DLEN / 8,
    localparam int unsigned OffW      = $clog2(BeatBytes)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [OffW-1:0]          cmd_offset_i,
    input  logic [LenBits-1:0]       cmd_len_i,
    input  logic                     beat_valid_i,
    output logic                     beat_ready_o,
    input  logic [8*BeatBytes-1:0]   beat_data_i,
    input  logic                     beat_last_i,
    output logic                     line_valid_o,
    input  logic                     line_ready_i,
    output logic [8*LineBytes-1:0]   line_nb_o,
    output logic [2*LineBytes-1:0]   line_en_o,
    output logic                     line_last_o,
    output logic                     err_o
);

    localparam int unsigned RdW = OffW + 1;
    localparam int unsigned WrW = $clog2(LineBytes) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PACK,
        DRAIN
    } state_e;

    state_e                 state_q;
    logic [RdW-1:0]         rd_off_q;
    logic [WrW-1:0]         wr_ptr_q;
    logic [LenBits-1:0]     rem_q;
    logic                   line_valid_q;
    logic                   line_last_q;
    logic                   err_q;
    logic [8*LineBytes-1:0] line_q, line_d;
    logic [2*LineBytes-1:0] en_q, en_d;

    logic [LenBits-1:0] room_beat, room_line, n, rem_left;
    logic               packing, move, beat_end, line_end, consume, done;

    always_comb begin
        room_beat = LenBits'(BeatBytes) - LenBits'(rd_off_q);
        room_line = LenBits'(LineBytes) - LenBits'(wr_ptr_q);
        n         = room_beat;
        if (room_line < n) n = room_line;
        if (rem_q < n)     n = rem_q;
        rem_left  = rem_q - n;
        done      = (rem_left == '0);
        beat_end  = (room_beat == n) || done;
        line_end  = (room_line == n) || done;
        packing   = (state_q == PACK) && !line_valid_q;
        move      = packing && beat_valid_i;
        consume   = move && beat_end;
    end

    // Byte lane j of the line takes beat byte (j - wr_ptr + rd_off) when in range.
    always_comb begin
        int               rel;
        logic [OffW-1:0]  src;
        line_d = line_q;
        en_d   = en_q;
        rel    = 0;
        src    = '0;
        for (int j = 0; j < int'(LineBytes); j++) begin
            rel = j - int'(wr_ptr_q);
            src = OffW'(rel + int'(rd_off_q));
            if (rel >= 0 && rel < int'(n)) begin
                line_d[8*j +: 8] = beat_data_i[8*src +: 8];
                en_d[2*j +: 2]   = 2'b11;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rd_off_q     <= '0;
            wr_ptr_q     <= '0;
            rem_q        <= '0;
            line_valid_q <= 1'b0;
            line_last_q  <= 1'b0;
            err_q        <= 1'b0;
            line_q       <= '0;
            en_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        rem_q    <= cmd_len_i;
                        rd_off_q <= {1'b0, cmd_offset_i};
                        wr_ptr_q <= '0;
                        state_q  <= PACK;
                    end
                end
                PACK: begin
                    if (line_valid_q) begin
                        if (line_ready_i) begin
                            line_valid_q <= 1'b0;
                            line_last_q  <= 1'b0;
                            en_q         <= '0;
                            wr_ptr_q     <= '0;
                        end
                    end else if (beat_valid_i) begin
                        line_q   <= line_d;
                        en_q     <= en_d;
                        rem_q    <= rem_left;
                        wr_ptr_q <= wr_ptr_q + WrW'(n);
                        rd_off_q <= consume ? '0 : rd_off_q + RdW'(n);
                        // Count is authoritative; beat_last only flags disagreement.
                        if (consume && (done != beat_last_i)) err_q <= 1'b1;
                        if (line_end) begin
                            line_valid_q <= 1'b1;
                            line_last_q  <= done;
                        end
                        if (done) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (line_valid_q && line_ready_i) begin
                        line_valid_q <= 1'b0;
                        line_last_q  <= 1'b0;
                        en_q         <= '0;
                        wr_ptr_q     <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign beat_ready_o = packing && beat_end;
    assign line_valid_o = line_valid_q;
    assign line_nb_o    = line_q;
    assign line_en_o    = en_q;
    assign line_last_o  = line_last_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mseq_load_packer.sv
// Randomized bench for mseq_load_packer against a byte-stream reference model.
// Expected lines are cut from the useful byte stream in 32-byte chunks.
module tb_mseq_load_packer;

    localparam int BB = 16;
    localparam int LB = 32;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           cmd_valid_i = 1'b0;
    logic           cmd_ready_o;
    logic [3:0]     cmd_offset_i = '0;
    logic [15:0]    cmd_len_i = '0;
    logic           beat_valid_i = 1'b0;
    logic           beat_ready_o;
    logic [127:0]   beat_data_i = '0;
    logic           beat_last_i = 1'b0;
    logic           line_valid_o;
    logic           line_ready_i = 1'b0;
    logic [255:0]   line_nb_o;
    logic [63:0]    line_en_o;
    logic           line_last_o;
    logic           err_o;

    mseq_load_packer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_offset_i(cmd_offset_i),
        .cmd_len_i   (cmd_len_i),
        .beat_valid_i(beat_valid_i),
        .beat_ready_o(beat_ready_o),
        .beat_data_i (beat_data_i),
        .beat_last_i (beat_last_i),
        .line_valid_o(line_valid_o),
        .line_ready_i(line_ready_i),
        .line_nb_o   (line_nb_o),
        .line_en_o   (line_en_o),
        .line_last_o (line_last_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [127:0] beats [16];
    logic [7:0]   exp_bytes [$];
    int           last_consume_cyc;
    int           last_valid_cyc;
    bit           err_exp = 1'b0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_beats(input int nb, input int bad_idx,
                               input bit final_last);
        int to;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk_i);
            beat_valid_i = 1'b1;
            beat_data_i  = beats[i];
            beat_last_i  = (i == nb - 1) ? final_last : (i == bad_idx);
            to = 0;
            while (!beat_ready_o && to < 200) begin
                @(negedge clk_i);
                to++;
            end
            if (to >= 200) begin
                check("beat_timeout", 1, 0);
                break;
            end
            if (i == nb - 1) last_consume_cyc = cyc;
        end
        @(negedge clk_i);
        beat_valid_i = 1'b0;
        beat_last_i  = 1'b0;
    endtask

    task automatic recv_lines(input int len, input int hold);
        int nl, to, cnt;
        logic [255:0] snap, exp_d, mask;
        logic [63:0]  snap_en, exp_en;
        nl = (len + LB - 1) / LB;
        for (int l = 0; l < nl; l++) begin
            to = 0;
            while (!line_valid_o && to < 300) begin
                @(negedge clk_i);
                to++;
            end
            if (to >= 300) begin
                check("line_timeout", 1, 0);
                break;
            end
            if (l == nl - 1) last_valid_cyc = cyc;
            check("bready_busy", beat_ready_o, 0);
            snap    = line_nb_o;
            snap_en = line_en_o;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                check("hold_valid", line_valid_o, 1);
                check("hold_data", line_nb_o, snap);
                check("hold_en", line_en_o, snap_en);
                check("hold_bready", beat_ready_o, 0);
            end
            cnt = len - l * LB;
            if (cnt > LB) cnt = LB;
            exp_d  = '0;
            exp_en = '0;
            mask   = '0;
            for (int k = 0; k < cnt; k++) begin
                exp_d[8*k +: 8]  = exp_bytes[l*LB + k];
                exp_en[2*k +: 2] = 2'b11;
                mask[8*k +: 8]   = 8'hff;
            end
            check("line_en", line_en_o, exp_en);
            check("line_data", line_nb_o & mask, exp_d);
            check("line_last", line_last_o, (l == nl - 1));
            line_ready_i = 1'b1;
            @(negedge clk_i);
            line_ready_i = 1'b0;
            check("valid_drop", line_valid_o, 0);
            if (l == nl - 1) check("idle_after", cmd_ready_o, 1);
        end
    endtask

    task automatic issue_cmd(input int offset, input int len);
        int to;
        @(negedge clk_i);
        cmd_valid_i  = 1'b1;
        cmd_offset_i = 4'(offset);
        cmd_len_i    = 16'(len);
        to = 0;
        while (!cmd_ready_o && to < 100) begin
            @(negedge clk_i);
            to++;
        end
        if (to >= 100) check("cmd_timeout", 1, 0);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    // err_mode: 0 clean, 1 final beat lacks last, 2 early beat flags last
    task automatic run_cmd(input int offset, input int len, input int hold,
                           input int err_mode);
        int nb, p, bad_idx, mode;
        bit final_last;
        nb = (offset + len + BB - 1) / BB;
        for (int i = 0; i < nb; i++)
            beats[i] = {$urandom, $urandom, $urandom, $urandom};
        exp_bytes.delete();
        for (int s = 0; s < len; s++) begin
            p = offset + s;
            exp_bytes.push_back(beats[p / BB][8*(p % BB) +: 8]);
        end
        mode = err_mode;
        if (mode == 2 && nb == 1) mode = 1;
        bad_idx    = -1;
        final_last = 1'b1;
        if (mode == 1) final_last = 1'b0;
        if (mode == 2) bad_idx = $urandom_range(0, nb - 2);
        if (mode != 0) err_exp = 1'b1;
        last_consume_cyc = -10;
        last_valid_cyc   = -20;
        issue_cmd(offset, len);
        fork
            drive_beats(nb, bad_idx, final_last);
            recv_lines(len, hold);
        join
        check("last_latency", last_valid_cyc, last_consume_cyc + 1);
        check("err", err_o, err_exp);
    endtask

    task automatic check_reset_outputs();
        check("rst_line_valid", line_valid_o, 0);
        check("rst_line_last", line_last_o, 0);
        check("rst_err", err_o, 0);
        check("rst_line_en", line_en_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_beat_ready", beat_ready_o, 0);
    endtask

    initial begin
        #12;
        check_reset_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_cmd(0, 32, 0, 0);
        run_cmd(4, 40, 0, 0);
        run_cmd(0, 64, 5, 0);
        run_cmd(15, 1, 0, 0);
        for (int t = 0; t < 25; t++)
            run_cmd($urandom_range(0, 15), $urandom_range(1, 100),
                    $urandom_range(0, 3), 0);
        run_cmd(0, 16, 0, 1);

        // Reset in the middle of packing
        beats[0] = {$urandom, $urandom, $urandom, $urandom};
        issue_cmd(3, 60);
        @(negedge clk_i);
        beat_valid_i = 1'b1;
        beat_data_i  = beats[0];
        @(negedge clk_i);
        @(negedge clk_i);
        check("pack_busy", cmd_ready_o, 0);
        #2;
        rst_ni       = 1'b0;
        beat_valid_i = 1'b0;
        #1;
        err_exp = 1'b0;
        check_reset_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_cmd($urandom_range(0, 15), $urandom_range(1, 100), 1, 0);
        run_cmd(7, 50, 2, 2);
        for (int t = 0; t < 5; t++)
            run_cmd($urandom_range(0, 15), $urandom_range(1, 100),
                    $urandom_range(0, 3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
